fifo_wr_arbiter: RTL

- Round-robin write arbiter that shares one FIFO write port between N_REQ producers.
- Each producer presents a valid/ready word stream.
- The arbiter grants one producer at a time for a burst of up to MAX_BURST words, drives the FIFO din/wen, and honours FIFO full as backpressure.
- Sits directly in front of the FIFO write side, in the same clock domain as the FIFO write clock.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/rr_pick.sv | 35 +++
 rtl/fifo_wr_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO/arbiter widths and the write-arbiter state encoding.
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH = 16;
    localparam int unsigned ARB_N_REQ  = 4;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request at or above start (with wrap), masked by excl.
module rr_pick #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    input  logic [N-1:0]     excl,
    output logic [N-1:0]     winner,
    output logic             found
);

    logic [N-1:0] cand;

    function automatic int unsigned wrap_idx(input int unsigned s, input int unsigned k);
        int unsigned t;
        t = s + k;
        return (t >= N) ? (t - N) : t;
    endfunction

    assign cand = req & ~excl;

    // Scan N positions starting at start; the first candidate hit becomes the one-hot winner.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && cand[IDX_W'(wrap_idx(32'(start), k))]) begin
                winner[IDX_W'(wrap_idx(32'(start), k))] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ valid/ready producers.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int unsigned N_REQ     = ARB_N_REQ,
    parameter int unsigned DATA_W    = FIFO_WIDTH,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        grant,
    input  logic                    fifo_full,
    output logic [DATA_W-1:0]       fifo_din,
    output logic                    fifo_wen,
    output logic                    busy
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    arb_state_e         state, state_n;
    logic [N_REQ-1:0]   grant_q, grant_n;
    logic [CNT_W-1:0]   burst_cnt, burst_cnt_n;
    logic [IDX_W-1:0]   last_owner, last_owner_n;

    logic [IDX_W-1:0]   owner;
    logic [DATA_W-1:0]  owner_data;
    logic               in_grant;
    logic               xfer;
    logic               owner_gap;
    logic               release_c;
    logic [IDX_W-1:0]   pick_base;
    logic [IDX_W-1:0]   pick_start;
    logic [N_REQ-1:0]   pick_excl;
    logic [N_REQ-1:0]   pick_win;
    logic               pick_found;

    // Encode the one-hot grant into an index and select that owner's word.
    always_comb begin
        owner      = '0;
        owner_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                owner      = IDX_W'(i);
                owner_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign in_grant  = (state == ST_GRANT);
    assign xfer      = in_grant && req_valid[owner] && !fifo_full;
    assign owner_gap = in_grant && !req_valid[owner];
    assign release_c = (xfer && (burst_cnt == CNT_W'(MAX_BURST - 1))) || owner_gap;

    // Search starts just past the owner when releasing, just past the last owner when idle.
    assign pick_base  = in_grant ? owner : last_owner;
    assign pick_start = (pick_base == IDX_W'(N_REQ - 1)) ? '0 : pick_base + IDX_W'(1);
    assign pick_excl  = owner_gap ? grant_q : '0;

    rr_pick #(
        .N (N_REQ)
    ) u_rr_pick (
        .req    (req_valid),
        .start  (pick_start),
        .excl   (pick_excl),
        .winner (pick_win),
        .found  (pick_found)
    );

    // Zero-latency write-side datapath toward the FIFO.
    assign req_ready = (in_grant && !fifo_full) ? grant_q : '0;
    assign fifo_wen  = xfer;
    assign fifo_din  = in_grant ? owner_data : '0;
    assign grant     = grant_q;
    assign busy      = in_grant;

    // State, grant, burst counter and rotation pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant_q    <= '0;
            burst_cnt  <= '0;
            last_owner <= IDX_W'(N_REQ - 1);
        end else begin
            state      <= state_n;
            grant_q    <= grant_n;
            burst_cnt  <= burst_cnt_n;
            last_owner <= last_owner_n;
        end
    end

    // Next-state: arbitrate from idle, count transfers, rotate on burst end or owner gap.
    always_comb begin
        state_n      = state;
        grant_n      = grant_q;
        burst_cnt_n  = burst_cnt;
        last_owner_n = last_owner;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_n     = ST_GRANT;
                    grant_n     = pick_win;
                    burst_cnt_n = '0;
                end
            end
            ST_GRANT: begin
                if (release_c) begin
                    last_owner_n = owner;
                    burst_cnt_n  = '0;
                    if (pick_found) begin
                        grant_n = pick_win;
                    end else begin
                        state_n = ST_IDLE;
                        grant_n = '0;
                    end
                end else if (xfer) begin
                    burst_cnt_n = burst_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                grant_n = '0;
            end
        endcase
    end

endmodule
